vmx_sync_fifo: RTL and testbench



---
 rtl/vmx_sync_fifo.sv | 154 +++++++++++++++
 tb/tb_vmx_sync_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vmx_sync_fifo.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output stage,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module vmx_sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, mem_cnt_s;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d, afull_q, afull_d;
  logic                  empty_q, empty_d, aempty_q, aempty_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc_s, rd_acc_s, bypass_s, mem_we_s;

  // Next-state logic: acceptance is judged on the registered flags of this cycle.
  always_comb begin
    wr_acc_s  = wr_en && !full_q && !flush;
    rd_acc_s  = rd_en && !empty_q && !flush;
    // Words held in the array, excluding one parked in the FWFT output stage.
    mem_cnt_s = count_q - {{ADDR_WIDTH{1'b0}}, valid_q};
    // FWFT pop of the last word with a concurrent push keeps the output stage busy.
    bypass_s  = (FWFT != 0) && wr_acc_s && rd_acc_s && (mem_cnt_s == CNT_ZERO);
    mem_we_s  = wr_acc_s && !bypass_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      ovf_d = ovf_q || (wr_en && full_q);
      udf_d = udf_q || (rd_en && empty_q);
      if (mem_we_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (FWFT != 0) begin
        if (bypass_s) begin
          dout_d  = din;
          valid_d = 1'b1;
        end else if ((rd_acc_s || !valid_q) && (mem_cnt_s != CNT_ZERO)) begin
          dout_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          valid_d  = 1'b1;
        end else if (rd_acc_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end else begin
        valid_d = 1'b0;
        if (rd_acc_s) begin
          dout_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
          dout_d = dout_q;
        end
      end
    end
    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    empty_d  = (FWFT != 0) ? !valid_d : (count_d == CNT_ZERO);
  end

  // Control, flag and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign dout         = dout_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_vmx_sync_fifo.sv
// Directed vector table for the standard-mode FIFO, hand sequences for FWFT and
// asynchronous reset, and a scoreboarded random run on a 4-deep FIFO.
module tb_vmx_sync_fifo;

  typedef struct {
    logic        wr, rd, fl;
    logic [31:0] din;
    logic [4:0]  cnt;
    logic        emp, ful, af, ae;
    logic [31:0] dout;
    logic        ovf, udf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  // Standard mode, 16 x 32
  logic        s_fl, s_wr, s_rd, s_full, s_af, s_emp, s_ae, s_ovf, s_udf;
  logic [31:0] s_din, s_dout;
  logic [4:0]  s_cnt;
  // FWFT mode, 16 x 32
  logic        f_fl, f_wr, f_rd, f_full, f_af, f_emp, f_ae, f_ovf, f_udf;
  logic [31:0] f_din, f_dout;
  logic [4:0]  f_cnt;
  // Standard mode, 4 x 8
  logic        m_fl, m_wr, m_rd, m_full, m_af, m_emp, m_ae, m_ovf, m_udf;
  logic [7:0]  m_din, m_dout;
  logic [2:0]  m_cnt;

  vmx_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_fl), .wr_en(s_wr), .din(s_din),
    .full(s_full), .almost_full(s_af), .rd_en(s_rd), .dout(s_dout),
    .empty(s_emp), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf));

  vmx_sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(f_fl), .wr_en(f_wr), .din(f_din),
    .full(f_full), .almost_full(f_af), .rd_en(f_rd), .dout(f_dout),
    .empty(f_emp), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf));

  vmx_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(m_fl), .wr_en(m_wr), .din(m_din),
    .full(m_full), .almost_full(m_af), .rd_en(m_rd), .dout(m_dout),
    .empty(m_emp), .almost_empty(m_ae), .count(m_cnt),
    .overflow(m_ovf), .underflow(m_udf));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flags follow from the expected count by their definitions (DEPTH 16, thresholds 14 / 2).
  task automatic add(input logic wr, input logic rd, input logic fl, input logic [31:0] din,
                     input int cnt, input logic [31:0] dout, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.din = din;
    v.cnt = 5'(cnt);
    v.emp = (cnt == 0);
    v.ful = (cnt == 16);
    v.af = (cnt >= 14);
    v.ae = (cnt <= 2);
    v.dout = dout; v.ovf = ovf; v.udf = udf;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] mq[$];
    logic [7:0] expd, d;
    bit         w, r, wacc, racc;

    rst_n = 1'b0;
    {s_fl, s_wr, s_rd, f_fl, f_wr, f_rd, m_fl, m_wr, m_rd} = 9'd0;
    s_din = 32'd0; f_din = 32'd0; m_din = 8'd0;

    // ---- build the standard-mode vector table ----
    add(1'b0, 1'b0, 1'b0, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) add(1'b1, 1'b0, 1'b0, 32'(k), k + 1, 32'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'hEE, 16, 32'd0, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) add(1'b0, 1'b1, 1'b0, 32'd0, 15 - j, 32'(j), 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 0, 32'h0F, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'd0, 0, 32'h0F, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b0, 32'(100 + k), k + 1, 32'h0F, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) add(1'b1, 1'b1, 1'b0, 32'(105 + k), 5, 32'(100 + k), 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) add(1'b1, 1'b0, 1'b0, 32'(200 + k), 6 + k, 32'd119, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'hDD, 15, 32'd120, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 32'hCC, 0, 32'd120, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("fw reset dout", f_dout, 32'd0);
    chk("fw reset empty", 32'(f_emp), 32'd1);
    chk("small reset ae", 32'(m_ae), 32'd1);

    // ---- apply the table ----
    for (int i = 0; i < vq.size(); i++) begin
      s_wr = vq[i].wr; s_rd = vq[i].rd; s_fl = vq[i].fl; s_din = vq[i].din;
      @(negedge clk);
      chk($sformatf("v%0d count", i), 32'(s_cnt), 32'(vq[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(s_emp), 32'(vq[i].emp));
      chk($sformatf("v%0d full", i), 32'(s_full), 32'(vq[i].ful));
      chk($sformatf("v%0d almost_full", i), 32'(s_af), 32'(vq[i].af));
      chk($sformatf("v%0d almost_empty", i), 32'(s_ae), 32'(vq[i].ae));
      chk($sformatf("v%0d dout", i), s_dout, vq[i].dout);
      chk($sformatf("v%0d overflow", i), 32'(s_ovf), 32'(vq[i].ovf));
      chk($sformatf("v%0d underflow", i), 32'(s_udf), 32'(vq[i].udf));
    end
    s_wr = 1'b0; s_rd = 1'b0; s_fl = 1'b0;

    // ---- asynchronous reset at count 7 during a write ----
    s_rd = 1'b1;
    @(negedge clk);
    s_rd = 1'b0;
    chk("pre-reset underflow", 32'(s_udf), 32'd1);
    for (int k = 0; k < 7; k++) begin
      s_wr = 1'b1; s_din = 32'(48 + k);
      @(negedge clk);
    end
    chk("pre-reset count", 32'(s_cnt), 32'd7);
    s_din = 32'h99;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", 32'(s_cnt), 32'd0);
    chk("async rst empty", 32'(s_emp), 32'd1);
    chk("async rst almost_empty", 32'(s_ae), 32'd1);
    chk("async rst full", 32'(s_full), 32'd0);
    chk("async rst almost_full", 32'(s_af), 32'd0);
    chk("async rst dout", s_dout, 32'd0);
    chk("async rst overflow", 32'(s_ovf), 32'd0);
    chk("async rst underflow", 32'(s_udf), 32'd0);
    s_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s_wr = 1'b1; s_din = 32'h77;
    @(negedge clk);
    s_wr = 1'b0; s_rd = 1'b1;
    @(negedge clk);
    s_rd = 1'b0;
    chk("post-reset readback", s_dout, 32'h77);
    chk("post-reset empty", 32'(s_emp), 32'd1);

    // ---- FWFT mode ----
    f_wr = 1'b1; f_din = 32'hA5;
    @(negedge clk);
    f_wr = 1'b0;
    chk("fw empty after write edge", 32'(f_emp), 32'd1);
    chk("fw count after write edge", 32'(f_cnt), 32'd1);
    @(negedge clk);
    chk("fw empty next edge", 32'(f_emp), 32'd0);
    chk("fw dout A5", f_dout, 32'hA5);
    f_rd = 1'b1;
    @(negedge clk);
    f_rd = 1'b0;
    chk("fw empty after pop", 32'(f_emp), 32'd1);
    chk("fw count after pop", 32'(f_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      f_wr = 1'b1; f_din = 32'(k + 1);
      @(negedge clk);
    end
    f_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fw b2b%0d empty", k), 32'(f_emp), 32'd0);
      chk($sformatf("fw b2b%0d dout", k), f_dout, 32'(k + 1));
      chk($sformatf("fw b2b%0d count", k), 32'(f_cnt), 32'(3 - k));
      f_rd = 1'b1;
      @(negedge clk);
    end
    f_rd = 1'b0;
    chk("fw b2b final empty", 32'(f_emp), 32'd1);
    chk("fw b2b final count", 32'(f_cnt), 32'd0);
    // Sustained push+pop at occupancy 1
    f_wr = 1'b1; f_din = 32'h10;
    @(negedge clk);
    f_wr = 1'b0;
    @(negedge clk);
    chk("fw single dout", f_dout, 32'h10);
    f_wr = 1'b1; f_rd = 1'b1; f_din = 32'h11;
    @(negedge clk);
    f_wr = 1'b0;
    chk("fw pushpop dout", f_dout, 32'h11);
    chk("fw pushpop empty", 32'(f_emp), 32'd0);
    chk("fw pushpop count", 32'(f_cnt), 32'd1);
    @(negedge clk);
    chk("fw drained empty", 32'(f_emp), 32'd1);
    @(negedge clk);
    f_rd = 1'b0;
    chk("fw underflow", 32'(f_udf), 32'd1);

    // ---- random push/pop on the 4-deep FIFO against a queue model ----
    for (int c = 0; c < 100; c++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      d = 8'($urandom_range(0, 255));
      wacc = w && (mq.size() < 4);
      racc = r && (mq.size() > 0);
      expd = 8'd0;
      if (racc) expd = mq.pop_front();
      if (wacc) mq.push_back(d);
      m_wr = w; m_rd = r; m_din = d;
      @(negedge clk);
      chk($sformatf("rnd%0d count", c), 32'(m_cnt), 32'(mq.size()));
      chk($sformatf("rnd%0d full", c), 32'(m_full), 32'(mq.size() == 4));
      if (racc) chk($sformatf("rnd%0d dout", c), 32'(m_dout), 32'(expd));
    end
    m_wr = 1'b0; m_rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
